// File: rtl/comparator_operand_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | comparator_operand_seq_if                                        |
// | Operand A/B bus toward the comparator with valid/ready handshake.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface comparator_operand_seq_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             valid;
  logic             ready;

  modport master (output A, B, valid, input ready);
  modport slave  (input A, B, valid, output ready);
endinterface
`default_nettype wire

// File: rtl/comparator_operand_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | comparator_operand_seq                                           |
// | Operand source for the magnitude comparator: manual switch       |
// | capture or full (A,B) sweep. Optional macro CMP_SEQ_ABORT_EN     |
// | adds an abort input.                                             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module comparator_operand_seq #(
  parameter int WIDTH = 3,
  parameter int GAP   = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic [WIDTH-1:0]   SW_A,
  input  wire logic [WIDTH-1:0]   SW_B,
  input  wire logic               load,
  input  wire logic               auto,
  input  wire logic               start,
`ifdef CMP_SEQ_ABORT_EN
  input  wire logic               abort,
`endif
  comparator_operand_seq_if.master bus,
  output logic                    done,
  output logic [2*WIDTH:0]        count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESENT_M = 3'd1,
    PRESENT_S = 3'd2,
    GAP_WAIT  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [2*WIDTH-1:0] pair_next;
  logic               last_pair;
  logic               go_sweep;
  logic               abort_req;

  // B is the low half, so a plain increment wraps B into A.
  assign pair_next = {bus.A, bus.B} + (2*WIDTH)'(1);
  assign last_pair = &{bus.A, bus.B};
  assign go_sweep  = start & auto;

`ifdef CMP_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus.A     <= '0;
      bus.B     <= '0;
      bus.valid <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      gap_cnt   <= '0;
    end else if (abort_req && (state != IDLE)) begin
      state     <= IDLE;
      bus.valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go_sweep) begin
            bus.A     <= '0;
            bus.B     <= '0;
            count     <= '0;
            done      <= 1'b0;
            bus.valid <= 1'b1;
            state     <= PRESENT_S;
          end else if (load) begin
            bus.A     <= SW_A;
            bus.B     <= SW_B;
            count     <= '0;
            done      <= 1'b0;
            bus.valid <= 1'b1;
            state     <= PRESENT_M;
          end
        end
        PRESENT_M: begin
          if (bus.ready) begin
            bus.valid <= 1'b0;
            count     <= count + (2*WIDTH+1)'(1);
            state     <= IDLE;
          end
        end
        PRESENT_S: begin
          if (bus.ready) begin
            count <= count + (2*WIDTH+1)'(1);
            if (last_pair) begin
              bus.valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (GAP > 0) begin
              bus.valid <= 1'b0;
              gap_cnt   <= '0;
              state     <= GAP_WAIT;
            end else begin
              // Zero gap: next pair follows with valid held high.
              {bus.A, bus.B} <= pair_next;
            end
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            {bus.A, bus.B} <= pair_next;
            bus.valid      <= 1'b1;
            state          <= PRESENT_S;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comparator_operand_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_comparator_operand_seq                                        |
// | Self-checking bench: GAP=4 and GAP=0 instances side by side.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_comparator_operand_seq;
  localparam int W = 3;
  localparam int NPAIRS = 1 << (2 * W);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] sw_a = '0, sw_b = '0;
  logic load = 1'b0, auto_sel = 1'b0, start = 1'b0;
`ifdef CMP_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  logic done4, done0;
  logic [2*W:0] count4, count0;

  comparator_operand_seq_if #(.WIDTH(W)) bus4 ();
  comparator_operand_seq_if #(.WIDTH(W)) bus0 ();

  comparator_operand_seq #(.WIDTH(W), .GAP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .SW_A(sw_a), .SW_B(sw_b), .load(load),
    .auto(auto_sel), .start(start),
`ifdef CMP_SEQ_ABORT_EN
    .abort(abort),
`endif
    .bus(bus4), .done(done4), .count(count4));

  comparator_operand_seq #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .SW_A(sw_a), .SW_B(sw_b), .load(load),
    .auto(auto_sel), .start(start),
`ifdef CMP_SEQ_ABORT_EN
    .abort(abort),
`endif
    .bus(bus0), .done(done0), .count(count0));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sweep reference: pair n is (n / 2^W, n mod 2^W); count equals pairs accepted.
  task automatic sb(input string tag, input int gap,
                    input logic pv, input logic pr, input logic [W-1:0] pa, input logic [W-1:0] pb,
                    input logic v, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [2*W:0] cnt, inout int n, inout int idle);
    if (pv && pr) begin
      chk({tag, "_pair"}, {pa, pb}, {W'(n / (1 << W)), W'(n % (1 << W))});
      n++;
      if (n < NPAIRS && gap == 0) chk({tag, "_nobubble"}, v, 1);
      idle = v ? 0 : 1;
    end else if (pv && !pr) begin
      chk({tag, "_stall"}, {v, a, b}, {1'b1, pa, pb});
    end else if (!pv && v) begin
      if (n > 0) chk({tag, "_gap"}, idle, gap);
      idle = 0;
    end else if (!v && !d) begin
      idle++;
    end
    chk({tag, "_count"}, cnt, n);
  endtask

  typedef struct {
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    int           hold;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  vec_t vecs [4];

  int n4, n0, idle4, idle0;
  logic pv4, pr4, pv0, pr0;
  logic [W-1:0] pa4, pb4, pa0, pb0;

  initial begin
    vecs[0] = '{3'd5, 3'd3, 3, 3'd5, 3'd3};
    vecs[1] = '{3'd0, 3'd7, 0, 3'd0, 3'd7};
    vecs[2] = '{3'd7, 3'd7, 1, 3'd7, 3'd7};
    vecs[3] = '{3'd2, 3'd6, 5, 3'd2, 3'd6};
    bus4.ready = 1'b0;
    bus0.ready = 1'b0;

    // Asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {bus4.A, bus4.B, bus4.valid, done4, count4}, 0);
    chk("reset_outputs0", {bus0.A, bus0.B, bus0.valid, done0, count0}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Manual capture vectors
    foreach (vecs[i]) begin
      sw_a = vecs[i].sa;
      sw_b = vecs[i].sb;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("man_load", {bus4.valid, bus4.A, bus4.B}, {1'b1, vecs[i].ea, vecs[i].eb});
      chk("man_cnt0", count4, 0);
      sw_a = ~vecs[i].sa;
      for (int h = 0; h < vecs[i].hold; h++) begin
        step();
        chk("man_hold", {bus4.valid, bus4.A, bus4.B}, {1'b1, vecs[i].ea, vecs[i].eb});
      end
      bus4.ready = 1'b1;
      bus0.ready = 1'b1;
      step();
      chk("man_accept", {bus4.valid, bus4.A, bus4.B, count4}, {1'b0, vecs[i].ea, vecs[i].eb, 7'd1});
      chk("man_accept0", {bus0.valid, count0}, {1'b0, 7'd1});
      step();
      chk("man_idle", {bus4.valid, count4}, {1'b0, 7'd1});
      bus4.ready = 1'b0;
      bus0.ready = 1'b0;
    end

    // start with auto=0 is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_noauto", bus4.valid, 0);

    // Full sweeps: GAP=4 with ready tied high, GAP=0 with random backpressure
    auto_sel = 1'b1;
    start = 1'b1;
    bus4.ready = 1'b1;
    step();
    start = 1'b0;
    chk("sweep_first", {bus4.valid, bus4.A, bus4.B, bus0.valid, bus0.A, bus0.B}, {1'b1, 6'd0, 1'b1, 6'd0});
    n4 = 0; n0 = 0; idle4 = 0; idle0 = 0;
    for (int cyc = 0; cyc < 3000 && !(done4 && done0); cyc++) begin
      bus0.ready = 1'($urandom_range(0, 1));
      pv4 = bus4.valid; pr4 = bus4.ready; pa4 = bus4.A; pb4 = bus4.B;
      pv0 = bus0.valid; pr0 = bus0.ready; pa0 = bus0.A; pb0 = bus0.B;
      step();
      sb("g4", 4, pv4, pr4, pa4, pb4, bus4.valid, done4, bus4.A, bus4.B, count4, n4, idle4);
      sb("g0", 0, pv0, pr0, pa0, pb0, bus0.valid, done0, bus0.A, bus0.B, count0, n0, idle0);
    end
    chk("sweep_timeout", {done4, done0}, 2'b11);
    chk("sweep_end4", {bus4.valid, bus4.A, bus4.B, count4}, {1'b0, 6'h3f, 7'd64});
    chk("sweep_end0", {bus0.valid, bus0.A, bus0.B, count0}, {1'b0, 6'h3f, 7'd64});
    step();
    chk("done_hold", {done4, bus4.valid, bus4.A, bus4.B}, {2'b10, 6'h3f});

    // Simultaneous load+start with auto=1: sweep wins
    sw_a = 3'd5; sw_b = 3'd3;
    load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk("prio_auto", {bus4.valid, bus4.A, bus4.B, done4, count4}, {1'b1, 6'd0, 1'b0, 7'd0});

    // Reset asserted mid-cycle while sweeping
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid4", {bus4.A, bus4.B, bus4.valid, done4, count4}, 0);
    chk("reset_mid0", {bus0.A, bus0.B, bus0.valid, done0, count0}, 0);
    rst_n = 1'b1;
    bus4.ready = 1'b0;
    bus0.ready = 1'b0;
    step();

    // Simultaneous load+start with auto=0: manual capture
    auto_sel = 1'b0;
    sw_a = 3'd6; sw_b = 3'd1;
    load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk("prio_manual", {bus4.valid, bus4.A, bus4.B}, {1'b1, 3'd6, 3'd1});
    bus4.ready = 1'b1;
    step();
    bus4.ready = 1'b0;
    chk("prio_manual_acc", {bus4.valid, count4}, {1'b0, 7'd1});

`ifdef CMP_SEQ_ABORT_EN
    auto_sel = 1'b1;
    start = 1'b1;
    bus0.ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !(bus0.valid && bus0.A == 3'd2 && bus0.B == 3'd5); cyc++) step();
    chk("abort_reach", {bus0.valid, bus0.A, bus0.B, count0}, {1'b1, 3'd2, 3'd5, 7'd21});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_now", {bus0.valid, done0, bus0.A, bus0.B, count0}, {2'b00, 3'd2, 3'd5, 7'd21});
    step();
    chk("abort_idle", {bus0.valid, count0}, {1'b0, 7'd21});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_restart", {bus0.valid, bus0.A, bus0.B, count0}, {1'b1, 6'd0, 7'd0});
    bus0.ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comparator_operand_seq.md
Name: comparator_operand_seq

Overview:
- Upstream operand source for the 3-bit magnitude comparator stage: drives its A/B operand inputs.
- Two modes: manual capture of switch values on a load pulse, or automatic sweep of every (A,B) pair.
- Each pair is presented with a valid/ready handshake; the downstream registering stage asserts ready when it has sampled G/L/E.
- Counts accepted pairs and flags sweep completion for lab demo/self-check.

Parameters:
- WIDTH, 3, operand width in bits (A, B, SW_A, SW_B).
- GAP, 4, idle cycles inserted between accepted sweep pairs (0 allowed = back-to-back).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SW_A  input  WIDTH  manual operand A (switches, already synchronised).
- SW_B  input  WIDTH  manual operand B.
- load  input  1  one-cycle pulse: capture SW_A/SW_B (manual mode).
- auto  input  1  level: 1 selects sweep on start.
- start  input  1  one-cycle pulse: begin sweep when auto=1.
- ready  input  1  downstream accepted current pair.
- A  output  WIDTH  operand A to comparator.
- B  output  WIDTH  operand B to comparator.
- valid  output  1  A/B hold a pair not yet accepted.
- done  output  1  sweep completed.
- count  output  2*WIDTH+1  pairs accepted since last start/load.

Behaviour:
- One clock; reset asynchronous, active-low. Reset: A=0, B=0, valid=0, done=0, count=0, state IDLE.
- States: IDLE, PRESENT_M, PRESENT_S, GAP_WAIT, DONE.
- IDLE: load -> A<=SW_A, B<=SW_B, count<=0, valid<=1, next PRESENT_M. start&auto -> A<=0, B<=0, count<=0, done<=0, valid<=1, next PRESENT_S. start&!auto ignored.
- Simultaneous load and start in IDLE: start wins when auto=1, else load.
- PRESENT_M: valid=1; on ready -> valid<=0, count<=count+1, next IDLE.
- PRESENT_S: valid=1; on ready -> valid<=0, count<=count+1; if A=B=all-ones -> DONE; else GAP_WAIT if GAP>0, otherwise advance operands and remain PRESENT_S with valid=1 (no bubble).
- Advance order: B increments first; on B wrap (all-ones -> 0), A increments. Sequence (0,0),(0,1)..(0,7),(1,0)..(7,7) for WIDTH=3.
- GAP_WAIT: internal counter counts GAP cycles, then operands advance, valid<=1, next PRESENT_S.
- DONE: done=1, valid=0, A/B hold (7,7). start&auto -> restart sweep as from IDLE; load -> manual capture, done<=0.
- A/B never change while valid=1 and ready=0. ready while valid=0 ignored.
- load/start ignored in PRESENT_M, PRESENT_S, GAP_WAIT.
- count: registered, updates edge after handshake; full sweep = 2^(2*WIDTH) (64); no overflow possible.
- Latency: load/start to valid = 1 cycle; handshake to next valid = GAP+1 cycles (1 if GAP=0).
- Reset mid-sweep: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro CMP_SEQ_ABORT_EN. Defined: extra input port abort (1 bit); abort=1 in any non-IDLE state -> next edge valid<=0, done<=0, state IDLE; A/B/count hold. Abort takes priority over ready in the same cycle (count not incremented).
- Not defined: no abort port; sweep always runs to DONE or reset.

Test Plan:
- Reset: rst_n=0 mid-clock -> A=0,B=0,valid=0,done=0,count=0 without waiting for edge.
- Manual: SW_A=5, SW_B=3, load pulse -> next cycle A=5,B=3,valid=1; ready after 3 cycles -> A/B stable throughout, valid=0, count=1, state IDLE.
- Sweep GAP=4, ready tied 1: start&auto -> 64 pairs in order (0,0)..(7,7), 4-cycle gap each, done=1, count=64, A=7,B=7.
- Backpressure GAP=0: ready random 50% -> no pair skipped/duplicated, A/B stable while valid&!ready, count=64 at done.
- Priority: load and start same cycle with auto=1 -> sweep begins at (0,0); with auto=0 -> manual capture of SW_A/SW_B.
- CMP_SEQ_ABORT_EN: abort at pair (2,5) with ready=1 same cycle -> valid=0 next edge, count unchanged, IDLE; later start restarts at (0,0), count=0.
